// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and single-port memory arbiter between the CPU bus and the DMA engine.
// Optional restart-on-rewrite while busy is enabled by defining OAM_DMA_RESTART_EN.
module oam_dma_arbiter #(
    parameter int unsigned LEN          = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] DEST_BASE    = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [7:0]       dma_reg, dma_reg_next;
    logic [7:0]       latch, latch_next;
    logic             done_next;

    logic reg_hit, hram_hit, cpu_hram, reg_wr, stall, restart, last;

    assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
    assign hram_hit = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign cpu_hram = (cpu_rd | cpu_wr) & hram_hit & ~reg_hit;
    assign reg_wr   = cpu_wr & reg_hit;
    assign dma_busy = (state != IDLE);
    assign last     = (idx == LAST_IDX);
    // START never touches memory, so only READ/WRITE yield to an HRAM access
    assign stall    = cpu_hram && (state == READ || state == WRITE);

`ifdef OAM_DMA_RESTART_EN
    assign restart = dma_busy & reg_wr;
`else
    assign restart = 1'b0;
`endif

    always_comb begin
        mem_addr  = cpu_addr;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;

        if (reg_hit) begin
            cpu_rdata = dma_reg;
        end else if (dma_busy && !hram_hit) begin
            cpu_rdata = 8'hFF;
        end

        if (!dma_busy || cpu_hram) begin
            if (!reg_hit) begin
                mem_wr = cpu_wr;
                mem_rd = cpu_rd & ~cpu_wr;
            end
        end else if (!restart) begin
            case (state)
                READ: begin
                    mem_addr = {dma_reg, 8'h00} + 16'(idx);
                    mem_rd   = 1'b1;
                end
                WRITE: begin
                    mem_addr  = DEST_BASE + 16'(idx);
                    mem_wr    = 1'b1;
                    mem_wdata = latch;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        dma_reg_next = dma_reg;
        latch_next   = latch;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (reg_wr) begin
                    state_next   = START;
                    dma_reg_next = cpu_wdata;
                    idx_next     = '0;
                end
            end
            START: state_next = READ;
            READ: begin
                if (!stall) begin
                    latch_next = mem_rdata;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!stall) begin
                    if (last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (restart) begin
            state_next   = START;
            dma_reg_next = cpu_wdata;
            idx_next     = '0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            dma_reg  <= '0;
            latch    <= '0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            dma_reg  <= dma_reg_next;
            latch    <= latch_next;
            dma_done <= done_next;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: randomized memory contents and CPU traffic
// checked against transfer-level expectations (copied bytes, busy length, stall count).
module tb_oam_dma_arbiter;

    localparam int LEN = 160;
    localparam logic [15:0] DEST = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_busy;
    logic        dma_done;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  hram    [0:127];
    logic [7:0]  exp_dst [0:LEN-1];
    logic [7:0]  pre_dst [0:LEN-1];

    logic        pend;
    logic [15:0] pend_addr;
    logic [7:0]  pend_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    // The memory write presented during a cycle is committed at the start of the next one.
    task automatic next_cycle();
        @(negedge clk);
        if (pend) mem[pend_addr] = pend_data;
        pend = 1'b0;
    endtask

    task automatic settle();
        #1;
        pend      = mem_wr;
        pend_addr = mem_addr;
        pend_data = mem_wdata;
    endtask

    task automatic expect_from(input logic [7:0] page);
        for (int i = 0; i < LEN; i++) exp_dst[i] = mem[{page, 8'h00} + 16'(i)];
    endtask

    task automatic prefill_dest();
        for (int i = 0; i < LEN; i++) begin
            pre_dst[i] = 8'($urandom);
            mem[DEST + 16'(i)] = pre_dst[i];
        end
    endtask

    task automatic check_dest(input string tag, input int from, input int to, input logic copied);
        int bad = 0;
        for (int i = from; i < to; i++)
            if (mem[DEST + 16'(i)] !== (copied ? exp_dst[i] : pre_dst[i])) bad++;
        check(tag, bad, 0);
    endtask

    // mode 0: blocked CPU traffic, 1: HRAM reads, 2: register rewrite at idx 10, 3: reset at idx 50
    task automatic run(input int mode, input logic [7:0] page, input logic [7:0] page2,
                       output int busy_n, output int stalls);
        int k;
        int r;
        int act;
        int done_seen;
        logic [15:0] a;
        busy_n = 0;
        stalls = 0;
        done_seen = 0;
        a = 16'hFF90;
        next_cycle();
        drive(1'b0, 1'b1, 16'hFF46, page);
        settle();
        check("start_not_forwarded", {mem_rd, mem_wr}, 0);
        for (k = 0; k < 2000; k++) begin
            next_cycle();
            drive(1'b0, 1'b0, 16'h0000, 8'h00);
            if (!dma_busy) begin
                settle();
                break;
            end
            act = 0;
            case (mode)
                0: begin
                    r = int'($urandom_range(0, 9));
                    if (r < 6) act = r;
                end
                1: begin
                    if (k < 2) begin
                        act = 6;
                        a = 16'hFF90;
                    end else if ($urandom_range(0, 5) == 0) begin
                        act = 6;
                        a = 16'($urandom_range(32'hFF80, 32'hFFFE));
                    end
                end
                2: if (k == 21) act = 7;
                default: if (k == 101) act = 8;
            endcase
            case (act)
                1: drive(1'b1, 1'b0, 16'hC000, 8'h00);
                2: drive(1'b0, 1'b1, 16'h8000, 8'hAA);
                3: drive(1'b1, 1'b0, 16'hFF46, 8'h00);
                4: drive(1'b1, 1'b0, 16'hFFFF, 8'h00);
                5: drive(1'b1, 1'b0, 16'hFF7F, 8'h00);
                6: drive(1'b1, 1'b0, a, 8'h00);
                7: drive(1'b0, 1'b1, 16'hFF46, page2);
                default: ;
            endcase
            settle();
            busy_n++;
            if (dma_done) done_seen++;
            case (act)
                1: begin
                    check("blocked_rd_data", cpu_rdata, 8'hFF);
                    check("blocked_rd_no_mem", mem_rd && mem_addr == 16'hC000, 0);
                end
                2: check("blocked_wr_dropped", mem_wr && mem_addr == 16'h8000, 0);
                3: check("reg_read_busy", cpu_rdata, page);
                4: check("ffff_blocked", cpu_rdata, 8'hFF);
                5: check("ff7f_blocked", cpu_rdata, 8'hFF);
                6: begin
                    check("hram_rd_data", cpu_rdata, hram[a - 16'hFF80]);
                    check("hram_rd_port", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, a});
                    if (k > 0) stalls++;
                end
                7: check("reg_wr_busy_no_mem_wr", mem_wr, 0);
                8: begin
                    rst = 1'b1;
                    settle();
                    check("reset_abort_busy", dma_busy, 0);
                    check("reset_abort_strobes", {mem_rd, mem_wr, dma_done}, 0);
                    break;
                end
                default: ;
            endcase
        end
        if (mode != 3) begin
            if (k == 2000) check("busy_bound", dma_busy, 0);
            check("done_after_busy", dma_done, 1);
            check("no_done_while_busy", done_seen, 0);
            next_cycle();
            settle();
            check("done_single_pulse", dma_done, 0);
        end
    endtask

    initial begin
        int busy_n;
        int stalls;
        int bad;
        logic [7:0] page_b;

        pend = 1'b0;
        pend_addr = '0;
        pend_data = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hC000] = 8'h5A;
        mem[16'h8000] = 8'h00;
        mem[16'hFFFF] = 8'h12;
        mem[16'hFF7F] = 8'h34;
        mem[16'hFF90] = 8'h77;
        for (int i = 0; i < 128; i++) hram[i] = mem[16'hFF80 + 16'(i)];

        // Reset state
        next_cycle();
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        settle();
        check("reset_busy", dma_busy, 0);
        check("reset_done", dma_done, 0);
        check("reset_reg_read", cpu_rdata, 8'h00);
        check("reg_read_not_forwarded", mem_rd, 0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        settle();
        check("idle_no_strobes", {mem_rd, mem_wr}, 0);

        // Idle passthrough
        next_cycle();
        drive(1'b1, 1'b0, 16'hC000, 8'h00);
        settle();
        check("idle_rd_port", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 16'hC000});
        check("idle_rd_data", cpu_rdata, 8'h5A);
        next_cycle();
        drive(1'b0, 1'b1, 16'h8000, 8'h3C);
        settle();
        check("idle_wr_port", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'h8000, 8'h3C});
        next_cycle();
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        settle();
        check("idle_wr_landed", mem[16'h8000], 8'h3C);

        // Plain transfer from C1 with blocked CPU traffic
        expect_from(8'hC1);
        prefill_dest();
        run(0, 8'hC1, 8'h00, busy_n, stalls);
        check("busy_len_plain", busy_n, 1 + 2 * LEN);
        check_dest("dest_plain", 0, LEN, 1'b1);
        check("blocked_wr_mem_unchanged", mem[16'h8000], 8'h3C);
        next_cycle();
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        settle();
        check("reg_read_after", cpu_rdata, 8'hC1);

        // HRAM access extends busy by one cycle per stalled cycle
        page_b = 8'($urandom_range(8'h20, 8'h7F));
        expect_from(page_b);
        prefill_dest();
        run(1, page_b, 8'h00, busy_n, stalls);
        check("busy_len_stalled", busy_n, 1 + 2 * LEN + stalls);
        check_dest("dest_stalled", 0, LEN, 1'b1);

        // Register rewrite at idx 10
`ifdef OAM_DMA_RESTART_EN
        expect_from(8'hD0);
`else
        expect_from(8'hC1);
`endif
        prefill_dest();
        run(2, 8'hC1, 8'hD0, busy_n, stalls);
        next_cycle();
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        settle();
`ifdef OAM_DMA_RESTART_EN
        check("busy_len_rewrite", busy_n, 22 + 1 + 2 * LEN);
        check("reg_after_rewrite", cpu_rdata, 8'hD0);
`else
        check("busy_len_rewrite", busy_n, 1 + 2 * LEN);
        check("reg_after_rewrite", cpu_rdata, 8'hC1);
`endif
        check_dest("dest_rewrite", 0, LEN, 1'b1);

        // Reset at idx 50
        expect_from(8'hC1);
        prefill_dest();
        run(3, 8'hC1, 8'h00, busy_n, stalls);
        next_cycle();
        rst = 1'b0;
        settle();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            settle();
            if (mem_wr || dma_busy || dma_done) bad++;
        end
        check("post_reset_quiet", bad, 0);
        next_cycle();
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        settle();
        check("reg_read_after_reset", cpu_rdata, 8'h00);
        check_dest("dest_before_reset", 0, 50, 1'b1);
        check_dest("dest_untouched", 50, LEN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sequences the OAM DMA transfer and arbitrates the single-port system memory between the CPU bus interface (top-level addr_bus / rd / data) and the internal DMA engine.
- A CPU write to the DMA register starts a copy of LEN bytes from {src_hi, 8'h00} to DEST_BASE.
- While the copy runs, CPU accesses are blocked or given priority according to the rules below.

Parameters:
- LEN, 160: bytes per transfer; index counter width is clog2(LEN).
- DMA_REG_ADDR, 16'hFF46: CPU address of the DMA start/source register.
- DEST_BASE, 16'hFE00: first destination address (OAM).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data returned to CPU
- mem_addr  out  16  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid combinationally in the same cycle as mem_rd
- dma_busy  out  1  high in START/READ/WRITE
- dma_done  out  1  one-cycle registered pulse after the last byte is written

Behaviour:
- Reset (asynchronous): state=IDLE, idx=0, dma_reg=8'h00, data latch=0, dma_done=0.
  - All memory strobes then follow the CPU passthrough (combinational).
  - A reset mid-transfer aborts immediately; no further DMA strobes are issued.
- States are IDLE, START, READ and WRITE.
  - IDLE -> START: CPU write to DMA_REG_ADDR. dma_reg <= cpu_wdata, idx <= 0.
  - START -> READ: after exactly 1 cycle. START makes no memory access.
  - READ: drive mem_addr={dma_reg, 8'h00}+idx and mem_rd=1. Latch mem_rdata at the clock edge, then go to WRITE.
  - WRITE: drive mem_addr=DEST_BASE+idx, mem_wr=1, mem_wdata=latch.
    - If idx==LEN-1: go to IDLE and pulse dma_done the next cycle.
    - Otherwise: idx+1, go to READ.
- Unstalled latency:
  - A start write sampled at edge n gives dma_busy high for 1+2*LEN cycles (321 at default).
  - dma_done is high in the first cycle after busy falls.
- Source high byte is used as written; no echo or mirroring. Address addition is 16-bit and wraps modulo 2^16.
- DMA register access:
  - Handled internally; never forwarded to memory.
  - A read of DMA_REG_ADDR returns dma_reg in any state.
- CPU access while idle: pure passthrough. mem_addr/mem_rd/mem_wr/mem_wdata = CPU signals; cpu_rdata=mem_rdata.
- CPU access while busy:
  - FF80-FFFE (HRAM): the CPU owns the port that cycle and the DMA stalls.
    - A stalled READ latches nothing; a stalled WRITE is retried.
    - State and idx hold, so busy is extended by one cycle per stalled cycle.
    - In START there is no conflict and no stall.
  - All other addresses: reads return 8'hFF and writes are dropped (no mem_wr).
  - The exception is DMA_REG_ADDR; see Optional Feature.
- Simultaneous cpu_rd and cpu_wr: the write wins; cpu_rdata is don't-care.
- When no access is active, mem_rd=mem_wr=0.

Optional Feature:
- Macro: OAM_DMA_RESTART_EN.
- Defined: a CPU write to DMA_REG_ADDR while busy loads dma_reg, clears idx, and enters START. Any in-flight WRITE that cycle is abandoned.
- Undefined: such a write is ignored. dma_reg is unchanged and the transfer completes on its original schedule.

Test Plan:
1. Idle: mem[C000]=5A, CPU reads C000 -> mem_rd=1, mem_addr=C000, cpu_rdata=5A. CPU writes 8000=3C -> mem_wr=1, mem_wdata=3C.
2. mem[C100+i]=i for i=0..159; CPU writes FF46=C1 at edge n -> dma_busy high for 321 cycles, dma_done pulses once, mem[FE00+i]=i for all i, CPU read FF46 returns C1.
3. During busy, CPU reads C000 -> cpu_rdata=FF with no CPU-driven mem_rd. CPU writes 8000=AA -> mem[8000] unchanged.
4. During a READ cycle, CPU reads FF90 (=77) -> cpu_rdata=77; busy lasts 322 cycles; copied data is still correct.
5. At idx=10, CPU writes FF46=D0. Undefined macro: source C1 is used for all 160 bytes, busy=321. With OAM_DMA_RESTART_EN: restarts from D000; after completion mem[FE00+i]=mem[D000+i].
6. Assert rst at idx=50 -> dma_busy=0 immediately, no mem_wr afterward, FF46 reads 00, mem[FE32..FE9F] untouched.
